// File: rtl/qbus_rr_arbiter.sv
// Round-robin arbiter sharing the q_m memory bus between instruction, data and DMA masters.
// One transaction at a time; a watchdog force-completes stalled accesses and logs the fault.
module qbus_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_access,
  input  logic [18:0] m0_addr,
  input  logic        m0_wr_en,
  input  logic [15:0] m0_wdata,
  input  logic [1:0]  m0_bytesel,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_access,
  input  logic [18:0] m1_addr,
  input  logic        m1_wr_en,
  input  logic [15:0] m1_wdata,
  input  logic [1:0]  m1_bytesel,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  input  logic        m2_access,
  input  logic [18:0] m2_addr,
  input  logic        m2_wr_en,
  input  logic [15:0] m2_wdata,
  input  logic [1:0]  m2_bytesel,
  output logic        m2_ack,
  output logic [15:0] m2_rdata,
  output logic        q_m_access,
  output logic [18:0] q_m_addr,
  output logic        q_m_wr_en,
  output logic [15:0] q_m_data_out,
  output logic [1:0]  q_m_bytesel,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack,
  output logic        timeout_flag,
  output logic [1:0]  timeout_master,
  output logic [18:0] timeout_addr,
  input  logic        timeout_clr
);

  localparam int unsigned DW = 16;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q;
  logic [1:0]      last_q;
  logic [TO_W-1:0] to_cnt_q;

  logic [2:0]      req;
  logic [1:0]      ord0, ord1, ord2;
  logic            pick_valid;
  logic [1:0]      pick;
  logic            busy, ack_ok, to_hit, txn_end;
  logic [DW-1:0]   resp_data;

  assign req = {m2_access, m1_access, m0_access};

  // Search order starts just after the most recently served master.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (last_q)
      2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    pick_valid = 1'b0;
    pick       = ord0;
    if (req[ord0]) begin
      pick_valid = 1'b1;
      pick       = ord0;
    end else if (req[ord1]) begin
      pick_valid = 1'b1;
      pick       = ord1;
    end else if (req[ord2]) begin
      pick_valid = 1'b1;
      pick       = ord2;
    end
  end

  // A slave ack on the watchdog cycle takes precedence over the forced completion.
  assign busy      = (state_q == ST_BUSY);
  assign ack_ok    = busy & q_m_ack;
  assign to_hit    = busy & ~q_m_ack & (to_cnt_q == TO_LAST);
  assign txn_end   = ack_ok | to_hit;
  assign resp_data = ack_ok ? q_m_data_in : 16'hFFFF;

  assign m0_ack   = txn_end & (grant_q == 2'd0);
  assign m1_ack   = txn_end & (grant_q == 2'd1);
  assign m2_ack   = txn_end & (grant_q == 2'd2);
  assign m0_rdata = m0_ack ? resp_data : '0;
  assign m1_rdata = m1_ack ? resp_data : '0;
  assign m2_rdata = m2_ack ? resp_data : '0;

  // Shared bus payload follows the grant only while a transaction is in flight.
  always_comb begin
    q_m_addr     = '0;
    q_m_wr_en    = 1'b0;
    q_m_data_out = '0;
    q_m_bytesel  = '0;
    if (busy) begin
      case (grant_q)
        2'd0: begin
          q_m_addr     = m0_addr;
          q_m_wr_en    = m0_wr_en;
          q_m_data_out = m0_wdata;
          q_m_bytesel  = m0_bytesel;
        end
        2'd1: begin
          q_m_addr     = m1_addr;
          q_m_wr_en    = m1_wr_en;
          q_m_data_out = m1_wdata;
          q_m_bytesel  = m1_bytesel;
        end
        2'd2: begin
          q_m_addr     = m2_addr;
          q_m_wr_en    = m2_wr_en;
          q_m_data_out = m2_wdata;
          q_m_bytesel  = m2_bytesel;
        end
        default: begin
          q_m_addr     = '0;
          q_m_wr_en    = 1'b0;
          q_m_data_out = '0;
          q_m_bytesel  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_BUSY;
      ST_BUSY: if (txn_end)    state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant, fairness pointer, watchdog counter and fault log.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_m_access     <= 1'b0;
      grant_q        <= 2'd0;
      last_q         <= 2'd2;
      to_cnt_q       <= '0;
      timeout_flag   <= 1'b0;
      timeout_master <= 2'd0;
      timeout_addr   <= '0;
    end else begin
      q_m_access <= (state_d == ST_BUSY);
      if ((state_q == ST_IDLE) && pick_valid) begin
        grant_q  <= pick;
        to_cnt_q <= '0;
      end else if (busy && (to_cnt_q != '1)) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (txn_end) begin
        last_q <= grant_q;
      end
      if (to_hit) begin
        timeout_flag   <= 1'b1;
        timeout_master <= grant_q;
        timeout_addr   <= q_m_addr;
      end else if (timeout_clr) begin
        timeout_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qbus_rr_arbiter.sv
// Scoreboard bench for qbus_rr_arbiter: directed transactions push expected acks,
// a negedge monitor pops and compares whenever an ack or bus activity appears.
module tb_qbus_rr_arbiter;

  localparam int unsigned TO_CYC = 8;
  localparam int unsigned TO_W   = 3;

  typedef struct packed {
    logic [1:0]  master;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  acc_t;
  logic [18:0] addr_t [3];
  logic        wr_t   [3];
  logic [15:0] wd_t   [3];
  logic [1:0]  bs_t   [3];

  logic        m0_ack, m1_ack, m2_ack;
  logic [15:0] m0_rdata, m1_rdata, m2_rdata;
  logic        q_m_access, q_m_wr_en, q_m_ack;
  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_out, q_m_data_in;
  logic [1:0]  q_m_bytesel;
  logic        timeout_flag, timeout_clr;
  logic [1:0]  timeout_master;
  logic [18:0] timeout_addr;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q [$];
  int          ack_cyc_q [$];
  int          cyc = 0;
  int          ack_total = 0;
  int          acc_run = 0;
  int          last_run = 0;
  int          slave_lat = 0;
  int          bcnt = 0;
  logic        slv_ack = 1'b0;
  logic        late_pulse = 1'b0;
  logic [15:0] data_key = 16'h0;
  logic [2:0]  mon_ak;
  logic [15:0] mon_rd [3];
  logic [1:0]  mon_h;
  exp_t        mon_e;

  qbus_rr_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_access(acc_t[0]), .m0_addr(addr_t[0]), .m0_wr_en(wr_t[0]), .m0_wdata(wd_t[0]),
    .m0_bytesel(bs_t[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_access(acc_t[1]), .m1_addr(addr_t[1]), .m1_wr_en(wr_t[1]), .m1_wdata(wd_t[1]),
    .m1_bytesel(bs_t[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .m2_access(acc_t[2]), .m2_addr(addr_t[2]), .m2_wr_en(wr_t[2]), .m2_wdata(wd_t[2]),
    .m2_bytesel(bs_t[2]), .m2_ack(m2_ack), .m2_rdata(m2_rdata),
    .q_m_access(q_m_access), .q_m_addr(q_m_addr), .q_m_wr_en(q_m_wr_en),
    .q_m_data_out(q_m_data_out), .q_m_bytesel(q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack),
    .timeout_flag(timeout_flag), .timeout_master(timeout_master),
    .timeout_addr(timeout_addr), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: acks on the slave_lat-th cycle of q_m_access (0 = never).
  always begin
    @(posedge clk);
    #1;
    if (q_m_access) bcnt++;
    else bcnt = 0;
    slv_ack = (slave_lat != 0) && q_m_access && (bcnt == slave_lat);
  end
  assign q_m_ack     = slv_ack | late_pulse;
  assign q_m_data_in = q_m_ack ? (q_m_addr[15:0] ^ data_key) : 16'h0;

  // Monitor: bus payload against scoreboard head, acks popped against expectations.
  always @(negedge clk) begin
    if (reset_n) begin
      mon_ak    = {m2_ack, m1_ack, m0_ack};
      mon_rd[0] = m0_rdata;
      mon_rd[1] = m1_rdata;
      mon_rd[2] = m2_rdata;
      if (q_m_access) begin
        acc_run++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_owner: got q_m_access=1 expected no transaction (cycle %0d)", cyc);
        end else begin
          mon_h = sb_q[0].master;
          chk("bus_addr",    64'(q_m_addr),     64'(addr_t[mon_h]));
          chk("bus_wr_en",   64'(q_m_wr_en),    64'(wr_t[mon_h]));
          chk("bus_wdata",   64'(q_m_data_out), 64'(wd_t[mon_h]));
          chk("bus_bytesel", 64'(q_m_bytesel),  64'(bs_t[mon_h]));
        end
      end else begin
        if (acc_run != 0) begin
          last_run = acc_run;
          acc_run  = 0;
        end
        chk("idle_bus", 64'({q_m_wr_en, q_m_bytesel, q_m_data_out, q_m_addr}), 64'(0));
      end
      chk("one_ack", 64'($countones(mon_ak) > 1), 64'(0));
      for (int i = 0; i < 3; i++) begin
        if (mon_ak[i]) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack on m%0d expected none (cycle %0d)", i, cyc);
          end else begin
            mon_e = sb_q.pop_front();
            chk("ack_master", 64'(i), 64'(mon_e.master));
            chk("ack_rdata",  64'(mon_rd[i]), 64'(mon_e.rdata));
          end
          ack_total++;
          ack_cyc_q.push_back(cyc);
        end else begin
          chk("rdata_idle", 64'(mon_rd[i]), 64'(0));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int k;
    k = 0;
    while (ack_total < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_acks", 64'(ack_total >= target), 64'(1));
  endtask

  task automatic push_exp(input logic [1:0] m, input logic [15:0] rd);
    exp_t e;
    e.master = m;
    e.rdata  = rd;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1, "bench time limit");
  end

  initial begin
    int tgt;
    acc_t       = 3'b000;
    timeout_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_t[i] = '0;
      wr_t[i]   = 1'b0;
      wd_t[i]   = '0;
      bs_t[i]   = 2'b11;
    end

    // Reset state
    step(2);
    chk("rst_bus", 64'({q_m_access, q_m_wr_en, q_m_bytesel, q_m_data_out, q_m_addr}), 64'(0));
    chk("rst_acks", 64'({m0_ack, m1_ack, m2_ack, m0_rdata, m1_rdata, m2_rdata}), 64'(0));
    chk("rst_timeout", 64'({timeout_flag, timeout_master, timeout_addr}), 64'(0));
    reset_n = 1'b1;
    step(1);

    // 1: single m1 read, slave acks on third bus cycle
    data_key  = 16'hBEEF;
    slave_lat = 3;
    addr_t[1] = 19'h00000;
    push_exp(2'd1, 16'hBEEF);
    acc_t[1] = 1'b1;
    wait_acks(ack_total + 1, 40);
    acc_t = 3'b000;
    step(2);
    chk("t1_access_len", 64'(last_run), 64'(3));

    // 2: all masters held from reset -> 0,1,2,0,1,2 spaced 3 cycles
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    data_key  = 16'h1234;
    slave_lat = 1;
    addr_t[0] = 19'h00100;
    addr_t[1] = 19'h00200;
    addr_t[2] = 19'h40300;
    acc_t     = 3'b111;
    step(2);
    ack_cyc_q.delete();
    for (int r = 0; r < 2; r++) begin
      push_exp(2'd0, 16'h1334);
      push_exp(2'd1, 16'h1034);
      push_exp(2'd2, 16'h1134);
    end
    tgt = ack_total + 6;
    reset_n = 1'b1;
    wait_acks(tgt, 60);
    acc_t = 3'b000;
    step(3);
    for (int i = 1; i < 6; i++) begin
      if (i < ack_cyc_q.size())
        chk("t2_grant_spacing", 64'(ack_cyc_q[i] - ack_cyc_q[i-1]), 64'(3));
      else
        chk("t2_ack_count", 64'(ack_cyc_q.size()), 64'(6));
    end

    // 3: m2 write, bus payload checked every cycle by the monitor
    slave_lat = 2;
    addr_t[2] = 19'h12345;
    wr_t[2]   = 1'b1;
    wd_t[2]   = 16'hA5A5;
    bs_t[2]   = 2'b01;
    push_exp(2'd2, 16'h3171);
    acc_t[2] = 1'b1;
    wait_acks(ack_total + 1, 40);
    acc_t = 3'b000;
    step(2);
    chk("t3_access_len", 64'(last_run), 64'(2));
    chk("t3_no_flag", 64'(timeout_flag), 64'(0));

    // 4: watchdog on m1, late slave reply ignored, clear works
    slave_lat = 0;
    addr_t[1] = 19'h7FFFF;
    push_exp(2'd1, 16'hFFFF);
    acc_t[1] = 1'b1;
    wait_acks(ack_total + 1, 40);
    acc_t = 3'b000;
    chk("t4_flag", 64'(timeout_flag), 64'(1));
    chk("t4_master", 64'(timeout_master), 64'(1));
    chk("t4_addr", 64'(timeout_addr), 64'(19'h7FFFF));
    late_pulse = 1'b1;
    #1;
    chk("t4_late_ack", 64'({m0_ack, m1_ack, m2_ack}), 64'(0));
    step(2);
    late_pulse = 1'b0;
    chk("t4_access_len", 64'(last_run), 64'(TO_CYC));
    chk("t4_flag_held", 64'(timeout_flag), 64'(1));
    timeout_clr = 1'b1;
    step(1);
    timeout_clr = 1'b0;
    chk("t4_flag_clr", 64'(timeout_flag), 64'(0));

    // 5: slave ack lands on the watchdog cycle -> normal completion
    slave_lat = TO_CYC;
    addr_t[0] = 19'h0ABCD;
    push_exp(2'd0, 16'hB9F9);
    acc_t[0] = 1'b1;
    wait_acks(ack_total + 1, 40);
    acc_t = 3'b000;
    step(2);
    chk("t5_access_len", 64'(last_run), 64'(TO_CYC));
    chk("t5_no_flag", 64'(timeout_flag), 64'(0));

    // 6: async reset mid-transaction, then m0 wins first despite last=0
    slave_lat = 0;
    addr_t[1] = 19'h11111;
    push_exp(2'd1, 16'h0000);
    acc_t[1] = 1'b1;
    for (int k = 0; k < 10 && !q_m_access; k++) step(1);
    chk("t6_started", 64'(q_m_access), 64'(1));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_access", 64'(q_m_access), 64'(0));
    chk("t6_async_bus", 64'({q_m_addr, m0_ack, m1_ack, m2_ack}), 64'(0));
    chk("t6_async_tolog", 64'({timeout_flag, timeout_addr}), 64'(0));
    sb_q.delete();
    slave_lat = 1;
    acc_t     = 3'b111;
    push_exp(2'd0, 16'hB9F9);
    push_exp(2'd1, 16'h0325);
    push_exp(2'd2, 16'h3171);
    tgt = ack_total + 3;
    step(1);
    reset_n = 1'b1;
    wait_acks(tgt, 40);
    acc_t = 3'b000;
    step(3);

    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
